// File: rtl/mdio_pkg.sv
// Shared MDIO definitions: frame field constants, FSM encoding and the
// helper that classifies an opcode as read-type or write-type.
package mdio_pkg;

    localparam logic [1:0] ST_C22       = 2'b01;
    localparam logic [1:0] ST_C45       = 2'b00;
    localparam logic [1:0] OP_C22_WR    = 2'b01;
    localparam logic [1:0] OP_C22_RD    = 2'b10;
    localparam logic [1:0] OP_C45_ADDR  = 2'b00;
    localparam logic [1:0] OP_C45_WR    = 2'b01;
    localparam logic [1:0] OP_C45_RDINC = 2'b10;
    localparam logic [1:0] OP_C45_RD    = 2'b11;
    localparam logic [1:0] TA_WR        = 2'b10;

    localparam int HDR_BITS   = 14;
    localparam int TA_BITS    = 2;
    localparam int DATA_BITS  = 16;
    localparam int FRAME_BITS = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4,
        S_REJ  = 3'd5
    } state_t;

    // C22 only reads on op 10 (00/11 fall back to write); C45 reads on 10/11.
    function automatic logic is_read_op(input logic c45, input logic [1:0] op);
        return c45 ? op[1] : (op == OP_C22_RD);
    endfunction

endpackage

// File: rtl/mdio_mdc_gen.sv
// MDC divider: toggles MDC every CLK_DIV cycles while run is high, low phase
// first, and flags the cycle just before each rising/falling MDC edge.
module mdio_mdc_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic mdc,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap      = run && (cnt == CW'(CLK_DIV - 1));
    assign rise_tick = wrap && !mdc;
    assign fall_tick = wrap && mdc;

    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (wrap) begin
            cnt <= '0;
            mdc <= !mdc;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mdio_master_v2.sv
// MDIO management master (Clause 22, optional Clause 45): takes one command
// over valid/ready, serialises it on MDC/MDIO and returns a one-cycle response.
module mdio_master_v2
    import mdio_pkg::*;
#(
    parameter int CLK_DIV      = 25,
    parameter int PREAMBLE_LEN = 32,
    parameter bit C45_EN       = 1'b0
) (
    input  logic        clk_app_i,
    input  logic        rst_clk_app_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_c45,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [15:0] rsp_rdata,
    output logic        o_mdc,
    output logic        o_mdo,
    output logic        o_mdo_oe,
    input  logic        i_mdi,
    output state_t      dbg_state
);

    localparam logic [4:0] PRE_LAST  = 5'(PREAMBLE_LEN - 1);
    localparam logic [4:0] HDR_LAST  = 5'(HDR_BITS - 1);
    localparam logic [4:0] TA_LAST   = 5'(TA_BITS - 1);
    localparam logic [4:0] DATA_LAST = 5'(DATA_BITS - 1);

    state_t        state, state_d;
    logic [4:0]    bit_cnt, bit_cnt_d;
    logic [31:0]   tx_q;
    logic [15:0]   rx_q;
    logic          is_read_q;
    logic          ready_q;
    logic          mdi_meta, mdi_s;
    logic          accept, reject, start, run, frame_done, rel_d;
    logic          rise_tick, fall_tick;
    logic [31:0]   frame_word;

    // A command transfers on any cycle where cmd_valid && cmd_ready; cmd_ready
    // is high only while idle and never in the cycle carrying rsp_valid.
    assign accept     = cmd_valid && ready_q;
    assign reject     = accept && cmd_c45 && !C45_EN;
    assign start      = accept && !reject;
    assign run        = start || (state inside {S_PRE, S_HDR, S_TA, S_DATA});
    assign frame_word = {(cmd_c45 ? ST_C45 : ST_C22), cmd_op, cmd_phyad, cmd_regad,
                         TA_WR, cmd_wdata};
    assign rel_d      = is_read_q && (state_d == S_TA || state_d == S_DATA);

    assign cmd_ready = ready_q;
    assign dbg_state = state;

    mdio_mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc_gen (
        .clk       (clk_app_i),
        .rst_n     (rst_clk_app_n),
        .run       (run),
        .mdc       (o_mdc),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // The state names the bit currently on the wire; it advances at fall ticks.
    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (reject) begin
                    state_d = S_REJ;
                end else if (start) begin
                    state_d   = (PREAMBLE_LEN > 0) ? S_PRE : S_HDR;
                    bit_cnt_d = '0;
                end
            end
            S_PRE: if (fall_tick) begin
                if (bit_cnt == PRE_LAST) begin
                    state_d   = S_HDR;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt + 1'b1;
                end
            end
            S_HDR: if (fall_tick) begin
                if (bit_cnt == HDR_LAST) begin
                    state_d   = S_TA;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt + 1'b1;
                end
            end
            S_TA: if (fall_tick) begin
                if (bit_cnt == TA_LAST) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt + 1'b1;
                end
            end
            S_DATA: if (fall_tick) begin
                if (bit_cnt == DATA_LAST) begin
                    state_d    = S_IDLE;
                    bit_cnt_d  = '0;
                    frame_done = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt + 1'b1;
                end
            end
            S_REJ:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_app_i) begin
        if (!rst_clk_app_n) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            ready_q   <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            is_read_q <= 1'b0;
            mdi_meta  <= 1'b1;
            mdi_s     <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            o_mdo     <= 1'b1;
            o_mdo_oe  <= 1'b0;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            ready_q   <= (state_d == S_IDLE) && !frame_done;
            mdi_meta  <= i_mdi;
            mdi_s     <= mdi_meta;
            rsp_valid <= frame_done || reject;
            if (reject) begin
                rsp_err <= 1'b1;
            end
            if (start) begin
                is_read_q <= is_read_op(cmd_c45, cmd_op);
                rsp_err   <= 1'b0;
                o_mdo_oe  <= 1'b1;
                if (PREAMBLE_LEN == 0) begin
                    o_mdo <= frame_word[FRAME_BITS-1];
                    tx_q  <= {frame_word[FRAME_BITS-2:0], 1'b0};
                end else begin
                    o_mdo <= 1'b1;
                    tx_q  <= frame_word;
                end
            end else if (fall_tick) begin
                if (frame_done) begin
                    o_mdo    <= 1'b1;
                    o_mdo_oe <= 1'b0;
                end else if (state_d == S_PRE) begin
                    o_mdo <= 1'b1;
                end else begin
                    // Released read bits keep o_mdo high so the pad idles at '1'.
                    o_mdo_oe <= !rel_d;
                    o_mdo    <= rel_d ? 1'b1 : tx_q[FRAME_BITS-1];
                    tx_q     <= {tx_q[FRAME_BITS-2:0], 1'b0};
                end
            end
            if (rise_tick && is_read_q) begin
                if (state == S_TA && bit_cnt == TA_LAST) begin
                    rsp_err <= mdi_s;
                end
                if (state == S_DATA) begin
                    rx_q <= {rx_q[14:0], mdi_s};
                end
            end
            if (frame_done && is_read_q) begin
                rsp_rdata <= rx_q;
            end
        end
    end

endmodule

// File: tb/tb_mdio_master_v2.sv
// Directed bench for mdio_master_v2: a vector table of complete commands on two
// parameterisations, plus hand sequences for rejection, mid-frame reset and back-to-back.
module tb_mdio_master_v2;
    import mdio_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_a, valid_b;
    logic        cmd_c45;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_phyad, cmd_regad;
    logic [15:0] cmd_wdata;
    logic        i_mdi = 1'b1;

    logic        ready_a, rsp_valid_a, rsp_err_a, mdc_a, mdo_a, oe_a;
    logic        ready_b, rsp_valid_b, rsp_err_b, mdc_b, mdo_b, oe_b;
    logic [15:0] rdata_a, rdata_b;
    state_t      dbg_a, dbg_b;

    logic        sel;
    logic        ready_m, rsp_valid_m, rsp_err_m, mdc_m, mdo_m, oe_m;
    logic [15:0] rdata_m;
    state_t      dbg_m;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    // Monitor / PHY-model state
    logic [63:0] cap_mdo = '0;
    logic [63:0] cap_oe = '0;
    int          nbits = 0;
    logic        mdc_prev = 1'b0;
    int          frame_base;
    logic        phy_on;
    logic [15:0] phy_data;
    int          phy_pre;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mdio_master_v2 #(.CLK_DIV(3), .PREAMBLE_LEN(32), .C45_EN(1'b0)) dut_a (
        .clk_app_i(clk), .rst_clk_app_n(rst_n), .cmd_valid(valid_a), .cmd_ready(ready_a),
        .cmd_c45(cmd_c45), .cmd_op(cmd_op), .cmd_phyad(cmd_phyad), .cmd_regad(cmd_regad),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid_a), .rsp_err(rsp_err_a),
        .rsp_rdata(rdata_a), .o_mdc(mdc_a), .o_mdo(mdo_a), .o_mdo_oe(oe_a),
        .i_mdi(i_mdi), .dbg_state(dbg_a)
    );

    mdio_master_v2 #(.CLK_DIV(3), .PREAMBLE_LEN(0), .C45_EN(1'b1)) dut_b (
        .clk_app_i(clk), .rst_clk_app_n(rst_n), .cmd_valid(valid_b), .cmd_ready(ready_b),
        .cmd_c45(cmd_c45), .cmd_op(cmd_op), .cmd_phyad(cmd_phyad), .cmd_regad(cmd_regad),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid_b), .rsp_err(rsp_err_b),
        .rsp_rdata(rdata_b), .o_mdc(mdc_b), .o_mdo(mdo_b), .o_mdo_oe(oe_b),
        .i_mdi(i_mdi), .dbg_state(dbg_b)
    );

    assign ready_m     = sel ? ready_b     : ready_a;
    assign rsp_valid_m = sel ? rsp_valid_b : rsp_valid_a;
    assign rsp_err_m   = sel ? rsp_err_b   : rsp_err_a;
    assign mdc_m       = sel ? mdc_b       : mdc_a;
    assign mdo_m       = sel ? mdo_b       : mdo_a;
    assign oe_m        = sel ? oe_b        : oe_a;
    assign rdata_m     = sel ? rdata_b     : rdata_a;
    assign dbg_m       = sel ? dbg_b       : dbg_a;

    // Captures MDIO at each MDC rise; the PHY model drives i_mdi after each MDC fall.
    always @(negedge clk) begin
        int k;
        if (mdc_m && !mdc_prev) begin
            cap_mdo = {cap_mdo[62:0], mdo_m};
            cap_oe  = {cap_oe[62:0], oe_m};
            nbits   = nbits + 1;
        end
        if (!mdc_m && mdc_prev) begin
            k = nbits - frame_base;
            i_mdi = 1'b1;
            if (phy_on && k == phy_pre + 15)
                i_mdi = 1'b0;
            else if (phy_on && k >= phy_pre + 16 && k <= phy_pre + 31)
                i_mdi = phy_data[phy_pre + 31 - k];
        end
        mdc_prev = mdc_m;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(output int c);
        int n = 0;
        while (!ready_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 64'(ready_m), 64'd1);
        c = cyc;
    endtask

    task automatic wait_rsp(output int c);
        int n = 0;
        while (!rsp_valid_m && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("rsp_timeout", 64'(rsp_valid_m), 64'd1);
        c = cyc;
    endtask

    task automatic set_cmd(input logic c45, input logic [1:0] op, input logic [4:0] pa,
                           input logic [4:0] ra, input logic [15:0] wd);
        cmd_c45 = c45; cmd_op = op; cmd_phyad = pa; cmd_regad = ra; cmd_wdata = wd;
    endtask

    // Offers one command on the selected DUT and returns at the response cycle.
    task automatic issue(output int acc, output int rc, output int base);
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        wait_ready(acc);
        base = nbits;
        frame_base = nbits;
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
        wait_rsp(rc);
    endtask

    typedef struct packed {
        logic        sel;
        logic        c45;
        logic [1:0]  op;
        logic [4:0]  phyad;
        logic [4:0]  regad;
        logic [15:0] wdata;
        logic        phy_on;
        logic [15:0] phy_data;
        logic [6:0]  nb;
        logic [63:0] exp_frame;
        logic [63:0] exp_oe;
        logic [15:0] exp_lat;
        logic        exp_err;
        logic        chk_rdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int acc, rc, base, acc2, rc2, b0;
        logic [63:0] mask;

        rst_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0; sel = 1'b0;
        set_cmd(1'b0, 2'b00, 5'd0, 5'd0, 16'h0000);
        phy_on = 1'b0; phy_data = '0; phy_pre = 32; frame_base = 0;
        repeat (3) @(negedge clk);

        check("rst_ready",  64'(ready_a),     64'd0);
        check("rst_rspv",   64'(rsp_valid_a), 64'd0);
        check("rst_err",    64'(rsp_err_a),   64'd0);
        check("rst_rdata",  64'(rdata_a),     64'h0);
        check("rst_mdc",    64'(mdc_a),       64'd0);
        check("rst_mdo",    64'(mdo_a),       64'd1);
        check("rst_oe",     64'(oe_a),        64'd0);
        check("rst_state",  64'(dbg_m),       64'(S_IDLE));
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready_a", 64'(ready_a), 64'd1);
        check("rel_ready_b", 64'(ready_b), 64'd1);

        vecs[0] = '{1'b0, 1'b0, 2'b01, 5'd1, 5'd0, 16'h1140, 1'b0, 16'h0, 7'd64,
                    {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140},
                    64'hFFFF_FFFF_FFFF_FFFF, 16'd384, 1'b0, 1'b0, 16'h0};
        vecs[1] = '{1'b0, 1'b0, 2'b11, 5'd4, 5'd17, 16'h0F0F, 1'b0, 16'h0, 7'd64,
                    {32'hFFFF_FFFF, 2'b01, 2'b11, 5'd4, 5'd17, 2'b10, 16'h0F0F},
                    64'hFFFF_FFFF_FFFF_FFFF, 16'd384, 1'b0, 1'b0, 16'h0};
        vecs[2] = '{1'b0, 1'b0, 2'b10, 5'd0, 5'd1, 16'h0000, 1'b0, 16'h0, 7'd64,
                    {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd0, 5'd1, 2'b11, 16'hFFFF},
                    {32'hFFFF_FFFF, 14'h3FFF, 18'h0}, 16'd384, 1'b1, 1'b1, 16'hFFFF};
        vecs[3] = '{1'b0, 1'b0, 2'b10, 5'd3, 5'd2, 16'h1234, 1'b1, 16'hBEEF, 7'd64,
                    {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd3, 5'd2, 2'b11, 16'hFFFF},
                    {32'hFFFF_FFFF, 14'h3FFF, 18'h0}, 16'd384, 1'b0, 1'b1, 16'hBEEF};
        vecs[4] = '{1'b1, 1'b0, 2'b01, 5'd5, 5'd9, 16'hA5C3, 1'b0, 16'h0, 7'd32,
                    {32'h0, 2'b01, 2'b01, 5'd5, 5'd9, 2'b10, 16'hA5C3},
                    {32'h0, 32'hFFFF_FFFF}, 16'd192, 1'b0, 1'b0, 16'h0};
        vecs[5] = '{1'b1, 1'b1, 2'b00, 5'd2, 5'd1, 16'h1234, 1'b0, 16'h0, 7'd32,
                    {32'h0, 2'b00, 2'b00, 5'd2, 5'd1, 2'b10, 16'h1234},
                    {32'h0, 32'hFFFF_FFFF}, 16'd192, 1'b0, 1'b0, 16'h0};
        vecs[6] = '{1'b1, 1'b1, 2'b11, 5'd2, 5'd1, 16'h0000, 1'b1, 16'h5A17, 7'd32,
                    {32'h0, 2'b00, 2'b11, 5'd2, 5'd1, 2'b11, 16'hFFFF},
                    {32'h0, 14'h3FFF, 18'h0}, 16'd192, 1'b0, 1'b1, 16'h5A17};

        for (int i = 0; i < 7; i++) begin
            sel      = vecs[i].sel;
            phy_on   = vecs[i].phy_on;
            phy_data = vecs[i].phy_data;
            phy_pre  = vecs[i].sel ? 0 : 32;
            set_cmd(vecs[i].c45, vecs[i].op, vecs[i].phyad, vecs[i].regad, vecs[i].wdata);
            issue(acc, rc, base);
            mask = (vecs[i].nb == 7'd64) ? '1 : ((64'd1 << vecs[i].nb) - 64'd1);
            check($sformatf("v%0d_latency", i), 64'(rc - acc), 64'(vecs[i].exp_lat));
            check($sformatf("v%0d_nbits", i), 64'(nbits - base), 64'(vecs[i].nb));
            check($sformatf("v%0d_frame", i), cap_mdo & mask, vecs[i].exp_frame);
            check($sformatf("v%0d_oe", i), cap_oe & mask, vecs[i].exp_oe);
            check($sformatf("v%0d_err", i), 64'(rsp_err_m), 64'(vecs[i].exp_err));
            if (vecs[i].chk_rdata)
                check($sformatf("v%0d_rdata", i), 64'(rdata_m), 64'(vecs[i].exp_rdata));
            check($sformatf("v%0d_end_mdc", i), 64'(mdc_m), 64'd0);
            check($sformatf("v%0d_end_oe", i), 64'(oe_m), 64'd0);
            check($sformatf("v%0d_end_ready", i), 64'(ready_m), 64'd0);
            @(negedge clk);
            check($sformatf("v%0d_ready_after", i), 64'(ready_m), 64'd1);
            check($sformatf("v%0d_rspv_pulse", i), 64'(rsp_valid_m), 64'd0);
        end

        // Clause 45 on a C22-only master: immediate error, no MDC, rdata kept.
        sel = 1'b0; phy_on = 1'b0; phy_pre = 32;
        set_cmd(1'b1, 2'b11, 5'd1, 5'd1, 16'h0);
        issue(acc, rc, base);
        check("rej_latency", 64'(rc - acc), 64'd1);
        check("rej_err", 64'(rsp_err_a), 64'd1);
        check("rej_rdata", 64'(rdata_a), 64'hBEEF);
        check("rej_mdc", 64'(mdc_a), 64'd0);
        @(negedge clk);
        check("rej_ready", 64'(ready_a), 64'd1);
        check("rej_no_edges", 64'(nbits - base), 64'd0);

        // Reset in the middle of a read.
        phy_on = 1'b1; phy_data = 16'h1357;
        set_cmd(1'b0, 2'b10, 5'd1, 5'd1, 16'h0);
        valid_a = 1'b1;
        wait_ready(acc);
        base = nbits; frame_base = nbits;
        @(negedge clk);
        valid_a = 1'b0;
        for (int n = 0; n < 400 && (nbits - base) < 21; n++) @(negedge clk);
        check("midrst_reached", 64'(nbits - base), 64'd21);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_mdc", 64'(mdc_a), 64'd0);
        check("midrst_oe", 64'(oe_a), 64'd0);
        check("midrst_mdo", 64'(mdo_a), 64'd1);
        check("midrst_ready", 64'(ready_a), 64'd0);
        check("midrst_rdata", 64'(rdata_a), 64'h0);
        for (int n = 0; n < 3; n++) begin
            check("midrst_no_rsp", 64'(rsp_valid_a), 64'd0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_rel", 64'(ready_a), 64'd1);
        check("midrst_rsp_rel", 64'(rsp_valid_a), 64'd0);

        // cmd_valid held over two writes: back-to-back frames.
        phy_on = 1'b0;
        set_cmd(1'b0, 2'b01, 5'd7, 5'd3, 16'h0001);
        valid_a = 1'b1;
        wait_ready(acc);
        b0 = nbits; frame_base = nbits;
        @(negedge clk);
        wait_rsp(rc);
        check("b2b_lat1", 64'(rc - acc), 64'd384);
        check("b2b_ready_at_rsp", 64'(ready_a), 64'd0);
        @(negedge clk);
        check("b2b_ready_next", 64'(ready_a), 64'd1);
        acc2 = cyc;
        frame_base = nbits;
        @(negedge clk);
        valid_a = 1'b0;
        wait_rsp(rc2);
        check("b2b_gap", 64'(acc2 - rc), 64'd1);
        check("b2b_lat2", 64'(rc2 - acc2), 64'd384);
        check("b2b_edges", 64'(nbits - b0), 64'd128);
        check("b2b_err", 64'(rsp_err_a), 64'd0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
